outmem_drain: RTL
=================

Name: outmem_drain

Overview:
- Read-back engine for the output SRAM that macarray fills: the reader on the other end of the EN_O/RW_O/ADDR_O/RDATA_O port.
- On START it reads LEN consecutive 64-bit result words from address BASE upward and unpacks each word into four 16-bit elements.
- Elements leave on a valid/ready stream toward the host/test interface.
- Sits beside macarray; the top-level arbiter gives it the output-memory port only after macarray finishes.

Parameters:
- DATA_W, 64, SRAM word width.
- ELEM_W, 16, element width; DATA_W/ELEM_W = 4 lanes per word.
- ADDR_W, 4, SRAM address width (16 words).
- FIFO_D, 2, prefetch word-buffer depth.

Ports:
- CLK  in  1  clock, rising edge.
- RSTN  in  1  asynchronous active-low reset.
- START  in  1  one-cycle request; sampled only in IDLE.
- BASE  in  4  first word address, latched at START.
- LEN  in  5  number of words, 0..16, latched at START.
- BUSY  out  1  high from the cycle after START until DONE.
- DONE  out  1  one-cycle pulse at completion.
- EN_O  out  1  SRAM enable.
- RW_O  out  1  SRAM direction; this block always drives 0 (read).
- ADDR_O  out  4  SRAM address.
- RDATA_O  in  64  SRAM read data, valid 1 cycle after EN_O.
- DOUT  out  16  element data.
- DOUT_VALID  out  1  element valid.
- DOUT_READY  in  1  sink ready.
- DOUT_LAST  out  1  high on the final element of the transfer.

Behaviour:
- Reset values: BUSY=0, DONE=0, EN_O=0, RW_O=0, ADDR_O=0, DOUT=0, DOUT_VALID=0, DOUT_LAST=0. FIFO, counters and in-flight flag are cleared.
- Reset mid-transfer: everything returns to IDLE immediately. Partial data is discarded, and no DONE is issued.
- FSM IDLE:
  - START with LEN=0 -> DONE pulses the next cycle; BUSY stays 0.
  - START with LEN>0 -> go to RUN. Latch rd_addr=BASE, rd_left=LEN, el_left=4*LEN.
- FSM RUN:
  - Read-issue rule: EN_O=1 when rd_left>0 and (fifo_count + inflight) < FIFO_D. ADDR_O=rd_addr.
  - On issue: rd_addr increments modulo 16 (BASE=14, LEN=4 reads 14,15,0,1); rd_left decrements; inflight is set for one cycle.
  - Cycle after issue: RDATA_O is pushed into the FIFO unconditionally. The issue rule guarantees space; overflow is a design error, asserted in simulation.
  - When EN_O=0, ADDR_O holds its last value.
- Unpack:
  - The FIFO head word is presented lane 0 first (bits 15:0), then lane 1, lane 2, lane 3 (bits 63:48).
  - The lane index advances on each DOUT_VALID&&DOUT_READY handshake. The word is popped on the lane-3 handshake.
  - DOUT/DOUT_VALID are registered. First element appears no earlier than 2 cycles after the first EN_O.
- Handshake:
  - Once DOUT_VALID is high, DOUT is held stable and DOUT_VALID stays high until accepted.
  - A pop and a push in the same cycle are both allowed; fifo_count is unchanged.
- Throughput: with DOUT_READY held high, one element per cycle sustained; no bubbles between words.
- DOUT_LAST=1 exactly when el_left==1 and DOUT_VALID=1.
- On the final handshake: go to FSM DONE for one cycle (DONE=1), then IDLE.
- BUSY is 1 in RUN and DONE.
- START while BUSY is ignored.

Decomposition:
- Shared package holds:
  - DATA_W, ELEM_W, ADDR_W and LANES=DATA_W/ELEM_W.
  - SRAM depth 16.
  - RW encoding: RW_READ=0, RW_WRITE=1 (shared with macarray).
  - FSM state encoding IDLE/RUN/DONE.
- One natural sub-module, word_fifo: synchronous FIFO, FIFO_D entries of DATA_W bits, with push/pop/count, async active-low reset.

Test Plan:
- Reset, then START with BASE=0, LEN=1, SRAM[0]=0x0004_0003_0002_0001, ready always high -> DOUT sequence 0x0001, 0x0002, 0x0003, 0x0004. LAST on the 4th element. DONE one cycle after the 4th handshake.
- BASE=0, LEN=16, ready high -> 64 consecutive elements with no gaps. EN_O never has more than 2 words outstanding or buffered. LAST only on element 64.
- BASE=14, LEN=4 -> ADDR_O sequence 14, 15, 0, 1 (wrap); 16 elements in address order.
- LEN=3, DOUT_READY random 30% -> DOUT stable while VALID && !READY. All 12 elements correct, no FIFO overflow assertion.
- START with LEN=0 -> no EN_O, DONE one cycle later, BUSY stays 0. A START pulse during a LEN=8 transfer is ignored.
- RSTN asserted mid-transfer (after 5 elements of LEN=4) -> all outputs 0 immediately, no DONE. A new START with BASE=2, LEN=1 then completes correctly.

Source files
------------

// File: rtl/outmem_drain_pkg.sv
// Shared definitions for the output-memory read-back engine.
package outmem_drain_pkg;

  localparam int unsigned DATA_W     = 64;
  localparam int unsigned ELEM_W     = 16;
  localparam int unsigned ADDR_W     = 4;
  localparam int unsigned LANES      = DATA_W / ELEM_W;
  localparam int unsigned LANE_W     = $clog2(LANES);
  localparam int unsigned SRAM_DEPTH = 16;
  localparam int unsigned LEN_W      = $clog2(SRAM_DEPTH + 1);
  localparam int unsigned EL_W       = LEN_W + LANE_W;

  // SRAM direction encoding, shared with macarray
  typedef enum logic {
    RW_READ  = 1'b0,
    RW_WRITE = 1'b1
  } rw_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Extract element 'lane' of a word; lane 0 is the least significant
  function automatic logic [ELEM_W-1:0] lane_sel(input logic [DATA_W-1:0] word,
                                                 input logic [LANE_W-1:0] lane);
    return word[lane*ELEM_W +: ELEM_W];
  endfunction

endpackage

// File: rtl/outmem_drain_word_fifo.sv
// Small synchronous word FIFO with head and second-entry peek.
module word_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned W     = 64,
  localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  head,
  output logic [W-1:0]  peek1,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;

  function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Storage, pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= bump(wr_ptr);
      end
      if (pop) rd_ptr <= bump(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Head and the entry behind it, for back-to-back word hand-over
  always_comb begin
    head  = mem[rd_ptr];
    peek1 = mem[bump(rd_ptr)];
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && (count == CW'(DEPTH))));
  a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(pop && (count == '0)));

endmodule

// File: rtl/outmem_drain.sv
// Reads LEN words from the output SRAM and streams them out as 16-bit elements.
module outmem_drain
  import outmem_drain_pkg::*;
#(
  parameter int unsigned FIFO_D = 2
) (
  input  logic              CLK,
  input  logic              RSTN,
  input  logic              START,
  input  logic [ADDR_W-1:0] BASE,
  input  logic [LEN_W-1:0]  LEN,
  output logic              BUSY,
  output logic              DONE,
  output logic              EN_O,
  output logic              RW_O,
  output logic [ADDR_W-1:0] ADDR_O,
  input  logic [DATA_W-1:0] RDATA_O,
  output logic [ELEM_W-1:0] DOUT,
  output logic              DOUT_VALID,
  input  logic              DOUT_READY,
  output logic              DOUT_LAST
);

  localparam int unsigned CW    = $clog2(FIFO_D + 1);
  localparam int unsigned OCC_W = CW + 1;

  state_e              state;
  state_e              state_nxt;
  logic [ADDR_W-1:0]   rd_addr;
  logic [ADDR_W-1:0]   addr_hold;
  logic [LEN_W-1:0]    rd_left;
  logic [EL_W-1:0]     el_left;
  logic                inflight;
  logic                zero_done;
  logic [LANE_W-1:0]   lane;
  logic [ELEM_W-1:0]   dout_q;
  logic                dout_valid_q;

  logic [DATA_W-1:0]   head;
  logic [DATA_W-1:0]   second;
  logic [CW-1:0]       fifo_count;
  logic [OCC_W-1:0]    occ;
  logic                issue;
  logic                hs;
  logic                pop;
  logic                load;
  logic [DATA_W-1:0]   load_word;
  logic [LANE_W-1:0]   load_lane;
  logic                start_run;

  word_fifo #(
    .DEPTH (FIFO_D),
    .W     (DATA_W)
  ) u_fifo (
    .clk   (CLK),
    .rst_n (RSTN),
    .push  (inflight),
    .pop   (pop),
    .wdata (RDATA_O),
    .head  (head),
    .peek1 (second),
    .count (fifo_count)
  );

  // Handshake, occupancy and start qualification
  always_comb begin
    hs        = dout_valid_q && DOUT_READY;
    pop       = hs && (lane == LANE_W'(LANES - 1));
    occ       = {1'b0, fifo_count} + OCC_W'(inflight);
    start_run = (state == ST_IDLE) && START && (LEN != '0);
  end

  // State register
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next state and read-issue decision
  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    case (state)
      ST_IDLE: if (start_run) state_nxt = ST_RUN;
      ST_RUN: begin
        issue = (rd_left != '0) && (occ < OCC_W'(FIFO_D));
        if (hs && (el_left == EL_W'(1))) state_nxt = ST_DONE;
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Output register reload: the element in DOUT always belongs to the FIFO
  // head, so on the lane-3 handshake the next word is taken from the second
  // entry; this keeps the stream gap-free while still popping on handshake.
  always_comb begin
    load      = 1'b0;
    load_word = head;
    load_lane = '0;
    if (hs) begin
      if (lane != LANE_W'(LANES - 1)) begin
        load      = 1'b1;
        load_lane = lane + 1'b1;
      end else if (fifo_count >= CW'(2)) begin
        load      = 1'b1;
        load_word = second;
      end
    end else if (!dout_valid_q && (fifo_count != '0)) begin
      load = 1'b1;
    end
  end

  // Transfer counters, read address and element output register
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      rd_addr      <= '0;
      addr_hold    <= '0;
      rd_left      <= '0;
      el_left      <= '0;
      inflight     <= 1'b0;
      zero_done    <= 1'b0;
      lane         <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      zero_done <= (state == ST_IDLE) && START && (LEN == '0);
      inflight  <= issue;
      if (start_run) begin
        rd_addr <= BASE;
        rd_left <= LEN;
        el_left <= EL_W'(LEN) << LANE_W;
      end else begin
        if (issue) begin
          rd_addr   <= rd_addr + 1'b1;
          rd_left   <= rd_left - 1'b1;
          addr_hold <= rd_addr;
        end
        if (hs) el_left <= el_left - 1'b1;
      end
      if (load) begin
        dout_q       <= lane_sel(load_word, load_lane);
        lane         <= load_lane;
        dout_valid_q <= 1'b1;
      end else if (hs) begin
        dout_valid_q <= 1'b0;
      end
    end
  end

  // Port outputs
  always_comb begin
    BUSY       = (state != ST_IDLE);
    DONE       = (state == ST_DONE) || zero_done;
    EN_O       = issue;
    RW_O       = RW_READ;
    ADDR_O     = issue ? rd_addr : addr_hold;
    DOUT       = dout_q;
    DOUT_VALID = dout_valid_q;
    DOUT_LAST  = dout_valid_q && (el_left == EL_W'(1));
  end

endmodule
